unidade_funcional_r_pipe: RTL and testbench
===========================================

Name: unidade_funcional_r_pipe

Overview:
Parametrised, pipelined successor of the Tomasulo R-type functional unit. It accepts one operation per clock from the reservation station, carrying two operands, an opcode and a producer tag. The result passes through a configurable-latency pipeline and is offered to the Common Data Bus (CDB) with its tag under a request/grant handshake. Back-pressure from the CDB arbiter stalls the pipeline, and Busy tells the reservation station to hold issue.

Parameters:
DATA_W, 16, operand and result width in bits
TAG_W, 4, reservation-station tag width
LATENCY, 2, pipeline stages from issue to CDB request; legal range 1..8
SIGNED_SLT, 0, 1 = SLT compares two's-complement; 0 = unsigned compare

Ports:
Clock  input  1  single clock, all state on rising edge
Resetn  input  1  asynchronous, active-low reset
Ready_to_uf  input  1  issue valid from reservation station
A  input  DATA_W  operand A
B  input  DATA_W  operand B
Ufop  input  3  opcode: 000 NOP, 010 ADD, 011 SUB, 110 SLT, 111 CMP, others undefined
Tag_in  input  TAG_W  tag of the issuing reservation-station entry
Flush  input  1  synchronous kill of all in-flight operations
Cdb_grant  input  1  arbiter grants the CDB this cycle
Busy  output  1  unit cannot accept an issue this cycle
Q  output  DATA_W  result offered to the CDB
Tag_out  output  TAG_W  tag accompanying Q
Write_Enable_CDB  output  1  CDB request; Q and Tag_out valid
Done  output  1  one-cycle pulse: a result was accepted by the CDB on the previous edge

Behaviour:
- Reset (Resetn low, asynchronous): all stage valid bits are 0; Q=0, Tag_out=0, Write_Enable_CDB=0, Done=0. Busy=0 while in reset.
- Pipeline structure:
  - LATENCY register stages, each holding {valid, result, tag}.
  - The result is computed combinationally at issue and captured into stage 1. Later stages only delay it.
  - The last stage drives Q, Tag_out and Write_Enable_CDB (= last-stage valid) directly.
- Stall:
  - stall = Write_Enable_CDB && !Cdb_grant.
  - While stall is high, no stage advances and all outputs hold their values.
  - When stall is low, every stage shifts forward on the clock edge.
  - Bubbles are not compressed; the pipeline advances as a whole.
- Busy = stall (combinational). Issue is accepted only when Ready_to_uf && !Busy. Ready_to_uf while Busy is ignored; the reservation station must re-present the operation.
- Latency: an operation accepted at edge k asserts Write_Enable_CDB in the cycle following edge k+LATENCY-1, absent stalls. Throughput is one result per clock with Cdb_grant held high.
- Arithmetic (all results DATA_W bits):
  - ADD: A+B modulo 2^DATA_W; carry discarded.
  - SUB: A-B modulo 2^DATA_W.
  - SLT: 1 if A<B, else 0. Signedness follows SIGNED_SLT.
  - CMP: 1 if A==B, else 0. CMP produces a CDB write and Done like every other valid opcode.
- NOP and undefined opcodes are consumed (not Busy-blocked) but enter stage 1 with valid=0. They produce no CDB request and no Done.
- Done: registered. It is 1 in the cycle after an edge where Write_Enable_CDB && Cdb_grant held, otherwise 0. Tag_out is not held for Done; the reservation station samples the tag at grant.
- Flush:
  - At the next edge, all valid bits clear and Done clears. The issue presented in the same cycle is also discarded.
  - Flush overrides stall.
  - A grant in the flush cycle still counts as a CDB transfer for the arbiter, but no Done pulse follows.
- Simultaneous grant and issue in the last-stage-full case: the stall is released, so the issue is accepted in the same cycle. There is no bubble.
- Cdb_grant while Write_Enable_CDB=0 is ignored.
- Reset asserted mid-operation clears everything immediately. After Resetn rises, the first edge may accept an issue.

Test Plan:
- Reset then idle: Resetn=0 with random inputs -> Q=0, Tag_out=0, Write_Enable_CDB=0, Done=0, Busy=0.
- LATENCY=2, Cdb_grant=1, issue ADD A=16'hFFFF B=16'h0002 Tag_in=5 at edge k -> Write_Enable_CDB=1, Q=16'h0001, Tag_out=5 after edge k+1; Done=1 after edge k+2.
- Back-to-back SUB 7-9, SLT 3<5, CMP 4==4, grant held high -> consecutive cycles show Q=16'hFFFE, 1, 1 with correct tags; CMP also pulses Done.
- Stall: result pending with Cdb_grant=0 for 3 cycles -> Busy=1, Q/Tag_out stable, new Ready_to_uf ignored; grant for 1 cycle -> one Done pulse and the pipeline advances.
- SIGNED_SLT=1: SLT A=16'h8000 B=16'h0001 -> Q=1; with SIGNED_SLT=0 -> Q=0.
- NOP, opcode 101, then Flush with 2 ops in flight -> no Write_Enable_CDB and no Done for any of them; the next ADD issued completes normally.

Source files
------------

// File: rtl/unidade_funcional_r_pipe_if.sv
// rtl/unidade_funcional_r_pipe_if.sv - issue/CDB bundle between reservation station, R-type unit and CDB arbiter
interface unidade_funcional_r_pipe_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              Ready_to_uf;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        Ufop;
  logic [TAG_W-1:0]  Tag_in;
  logic              Flush;
  logic              Cdb_grant;
  logic              Busy;
  logic [DATA_W-1:0] Q;
  logic [TAG_W-1:0]  Tag_out;
  logic              Write_Enable_CDB;
  logic              Done;

  modport master (
    output Ready_to_uf, A, B, Ufop, Tag_in, Flush, Cdb_grant,
    input  Busy, Q, Tag_out, Write_Enable_CDB, Done
  );

  modport slave (
    input  Ready_to_uf, A, B, Ufop, Tag_in, Flush, Cdb_grant,
    output Busy, Q, Tag_out, Write_Enable_CDB, Done
  );
endinterface

// File: rtl/unidade_funcional_r_pipe.sv
// rtl/unidade_funcional_r_pipe.sv - pipelined Tomasulo R-type unit with CDB request/grant back-pressure
// The whole pipeline advances or holds as one; bubbles are never squeezed out.
module unidade_funcional_r_pipe #(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 4,
  parameter int LATENCY    = 2,
  parameter int SIGNED_SLT = 0
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  unidade_funcional_r_pipe_if.slave uf
);
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  res_q [LATENCY];
  logic [DATA_W-1:0]  res_d [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  logic               done_q, done_d;

  logic               slt;
  logic               op_valid;
  logic [DATA_W-1:0]  alu_res;
  logic               stall;

  always_comb begin
    if (SIGNED_SLT != 0) slt = $signed(uf.A) < $signed(uf.B);
    else                 slt = uf.A < uf.B;
  end

  // NOP and undefined opcodes still occupy a slot, just without a valid bit
  always_comb begin
    alu_res  = '0;
    op_valid = 1'b0;
    case (uf.Ufop)
      3'b010: begin alu_res = uf.A + uf.B;                               op_valid = 1'b1; end
      3'b011: begin alu_res = uf.A - uf.B;                               op_valid = 1'b1; end
      3'b110: begin alu_res = {{(DATA_W-1){1'b0}}, slt};                 op_valid = 1'b1; end
      3'b111: begin alu_res = {{(DATA_W-1){1'b0}}, (uf.A == uf.B)};      op_valid = 1'b1; end
      default: ;
    endcase
  end

  assign stall = vld_q[LATENCY-1] && !uf.Cdb_grant;

  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    tag_d  = tag_q;
    done_d = 1'b0;
    if (uf.Flush) begin
      vld_d = '0;
    end else if (!stall) begin
      vld_d[0] = uf.Ready_to_uf && op_valid;
      res_d[0] = alu_res;
      tag_d[0] = uf.Tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      done_d = vld_q[LATENCY-1] && uf.Cdb_grant;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vld_q  <= '0;
      res_q  <= '{default: '0};
      tag_q  <= '{default: '0};
      done_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      tag_q  <= tag_d;
      done_q <= done_d;
    end
  end

  assign uf.Busy             = stall;
  assign uf.Q                = res_q[LATENCY-1];
  assign uf.Tag_out          = tag_q[LATENCY-1];
  assign uf.Write_Enable_CDB = vld_q[LATENCY-1];
  assign uf.Done             = done_q;
endmodule

// File: tb/tb_unidade_funcional_r_pipe.sv
// tb/tb_unidade_funcional_r_pipe.sv - bench for unidade_funcional_r_pipe, two configurations driven in lockstep
module tb_unidade_funcional_r_pipe;
  logic        Clock = 1'b0;
  logic        Resetn;
  logic        rdy, flush, grant;
  logic [15:0] a, b;
  logic [2:0]  op;
  logic [3:0]  tag;
  int          checks = 0;
  int          errors = 0;

  unidade_funcional_r_pipe_if uf0 ();
  unidade_funcional_r_pipe_if uf1 ();

  assign uf0.Ready_to_uf = rdy;   assign uf1.Ready_to_uf = rdy;
  assign uf0.A           = a;     assign uf1.A           = a;
  assign uf0.B           = b;     assign uf1.B           = b;
  assign uf0.Ufop        = op;    assign uf1.Ufop        = op;
  assign uf0.Tag_in      = tag;   assign uf1.Tag_in      = tag;
  assign uf0.Flush       = flush; assign uf1.Flush       = flush;
  assign uf0.Cdb_grant   = grant; assign uf1.Cdb_grant   = grant;

  unidade_funcional_r_pipe #(.DATA_W(16), .TAG_W(4), .LATENCY(2), .SIGNED_SLT(0)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .uf(uf0));
  unidade_funcional_r_pipe #(.DATA_W(16), .TAG_W(4), .LATENCY(3), .SIGNED_SLT(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .uf(uf1));

  always #5 Clock = ~Clock;

  logic        obs_we [2];
  logic        obs_busy [2];
  logic        obs_done [2];
  logic [15:0] obs_q [2];
  logic [3:0]  obs_tag [2];
  assign obs_we[0]   = uf0.Write_Enable_CDB; assign obs_we[1]   = uf1.Write_Enable_CDB;
  assign obs_busy[0] = uf0.Busy;             assign obs_busy[1] = uf1.Busy;
  assign obs_done[0] = uf0.Done;             assign obs_done[1] = uf1.Done;
  assign obs_q[0]    = uf0.Q;                assign obs_q[1]    = uf1.Q;
  assign obs_tag[0]  = uf0.Tag_out;          assign obs_tag[1]  = uf1.Tag_out;

  // Reference: per configuration, a list of slots from issue to CDB offer
  int          lat [2] = '{2, 3};
  bit          sgn [2] = '{1'b0, 1'b1};
  logic        mv [2][8];
  logic [15:0] mr [2][8];
  logic [3:0]  mt [2][8];
  logic        md [2];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_op(input logic [2:0] o, input logic [15:0] x,
                                         input logic [15:0] y, input bit s);
    int ix, iy, r;
    ix = int'(x);
    iy = int'(y);
    if (s) begin
      if (ix >= 32768) ix = ix - 65536;
      if (iy >= 32768) iy = iy - 65536;
    end
    case (o)
      3'b010: begin r = int'(x) + int'(y);         return {1'b1, r[15:0]}; end
      3'b011: begin r = int'(x) - int'(y) + 65536; return {1'b1, r[15:0]}; end
      3'b110: return {1'b1, 15'd0, (ix < iy)};
      3'b111: return {1'b1, 15'd0, (x == y)};
      default: return 17'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        mv[d][i] = 1'b0; mr[d][i] = '0; mt[d][i] = '0;
      end
      md[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      int last = lat[d] - 1;
      chk($sformatf("we%0d", d),   obs_we[d],   mv[d][last]);
      chk($sformatf("done%0d", d), obs_done[d], md[d]);
      chk($sformatf("busy%0d", d), obs_busy[d], mv[d][last] && !grant);
      if (mv[d][last]) begin
        chk($sformatf("q%0d", d),   obs_q[d],   mr[d][last]);
        chk($sformatf("tag%0d", d), obs_tag[d], mt[d][last]);
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int          last = lat[d] - 1;
      logic [16:0] r    = ref_op(op, a, b, sgn[d]);
      if (flush) begin
        for (int i = 0; i < 8; i++) mv[d][i] = 1'b0;
        md[d] = 1'b0;
      end else if (!(mv[d][last] && !grant)) begin
        md[d] = mv[d][last] && grant;
        for (int i = last; i > 0; i--) begin
          mv[d][i] = mv[d][i-1]; mr[d][i] = mr[d][i-1]; mt[d][i] = mt[d][i-1];
        end
        mv[d][0] = rdy && r[16];
        mr[d][0] = r[15:0];
        mt[d][0] = tag;
      end else begin
        md[d] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    #3;
    check_outputs();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] t);
    rdy = 1'b1; op = o; a = x; b = y; tag = t;
  endtask

  task automatic idle();
    rdy = 1'b0; flush = 1'b0; grant = 1'b1;
  endtask

  task automatic reset_checks();
    model_reset();
    check_outputs();
    chk("rst_q0", uf0.Q, 16'h0);       chk("rst_q1", uf1.Q, 16'h0);
    chk("rst_tag0", uf0.Tag_out, 4'h0); chk("rst_tag1", uf1.Tag_out, 4'h0);
  endtask

  task automatic randomize_inputs();
    rdy   = 1'($urandom);
    op    = 3'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    tag   = 4'($urandom);
    grant = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    bit seen0, seen1;
    Resetn = 1'b0;
    model_reset();
    randomize_inputs();
    @(posedge Clock);
    #1;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      #3;
      reset_checks();
      @(posedge Clock);
      #1;
    end
    Resetn = 1'b1;
    idle();

    // ADD wraps: FFFF + 2 = 0001, visible after edge k+1 on the LATENCY=2 unit
    issue(3'b010, 16'hFFFF, 16'h0002, 4'd5);
    cycle();
    idle();
    cycle();
    chk("add_we", uf0.Write_Enable_CDB, 1'b1);
    chk("add_q", uf0.Q, 16'h0001);
    chk("add_tag", uf0.Tag_out, 4'd5);
    cycle();
    chk("add_done", uf0.Done, 1'b1);
    for (int n = 0; n < 4; n++) cycle();

    issue(3'b011, 16'd7, 16'd9, 4'd1); cycle();
    issue(3'b110, 16'd3, 16'd5, 4'd2); cycle();
    issue(3'b111, 16'd4, 16'd4, 4'd3); cycle();
    idle();
    for (int n = 0; n < 6; n++) cycle();

    // Back-pressure: hold grant low while the station keeps presenting work
    issue(3'b010, 16'd10, 16'd20, 4'd6); cycle();
    grant = 1'b0;
    issue(3'b011, 16'd50, 16'd8, 4'd7);
    for (int n = 0; n < 5; n++) cycle();
    chk("stall_busy0", uf0.Busy, 1'b1);
    chk("stall_q0", uf0.Q, 16'd30);
    idle();
    for (int n = 0; n < 6; n++) cycle();

    issue(3'b110, 16'h8000, 16'h0001, 4'd9); cycle();
    idle();
    seen0 = 1'b0; seen1 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      if (uf0.Write_Enable_CDB) begin seen0 = 1'b1; chk("slt_unsigned", uf0.Q, 16'h0000); end
      if (uf1.Write_Enable_CDB) begin seen1 = 1'b1; chk("slt_signed", uf1.Q, 16'h0001); end
    end
    chk("slt_seen0", seen0, 1'b1);
    chk("slt_seen1", seen1, 1'b1);

    issue(3'b000, 16'd1, 16'd1, 4'd10); cycle();
    issue(3'b101, 16'd2, 16'd2, 4'd11); cycle();
    idle(); cycle(); cycle();
    issue(3'b010, 16'd1, 16'd2, 4'd12); cycle();
    issue(3'b011, 16'd5, 16'd3, 4'd13); grant = 1'b0; cycle();
    issue(3'b010, 16'd9, 16'd9, 4'd14); flush = 1'b1; grant = 1'b1; cycle();
    idle();
    for (int n = 0; n < 4; n++) cycle();
    chk("flush_we0", uf0.Write_Enable_CDB, 1'b0);
    chk("flush_we1", uf1.Write_Enable_CDB, 1'b0);
    issue(3'b010, 16'h1234, 16'h1111, 4'd15); cycle();
    idle();
    for (int n = 0; n < 5; n++) cycle();

    // Asynchronous reset mid-flight
    issue(3'b010, 16'd3, 16'd4, 4'd8); cycle();
    issue(3'b111, 16'd3, 16'd3, 4'd4); cycle();
    Resetn = 1'b0;
    #1;
    reset_checks();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    idle();
    for (int n = 0; n < 3; n++) cycle();

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      cycle();
    end
    idle();
    for (int n = 0; n < 6; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
